nand_op_sequencer: RTL and testbench
====================================

Name: nand_op_sequencer

Overview:
- Computes a selected 2-input bitwise boolean function using one shared WIDTH-bit NAND cell, time-multiplexed over several clock cycles.
- Acts as the controller and scheduler for the NAND datapath, showing NAND universality in hardware.
- Accepts one operation at a time through a valid/ready input handshake.
- Returns the registered result through a valid/ready output handshake.

Parameters:
- WIDTH, 4, bit width of operands a, b and result y.
- CNT_W, 16, width of the NAND-evaluation counter nand_count.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  a, b, op are valid.
- in_ready  output  1  block can accept an operation.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B (ignored for NOT).
- op  input  2  function select: 00 NOT a, 01 AND, 10 OR, 11 XOR.
- out_valid  output  1  y holds a completed result.
- out_ready  input  1  consumer accepts y.
- y  output  WIDTH  registered result.
- busy  output  1  state is not IDLE.
- nand_count  output  CNT_W  total NAND evaluations since reset; wraps modulo 2^CNT_W.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; step=0.
  - y=0, out_valid=0, busy=0, nand_count=0.
  - Internal a/b/op/temp registers cleared.
  - in_ready forced 0 while rst_n is low.
- Reset mid-operation aborts the operation. No partial result is ever presented. After release the block is in IDLE.
- FSM states: IDLE, EXEC, DONE.
  - in_ready = 1 only in IDLE. busy = 1 in EXEC and DONE.
- IDLE:
  - On an edge with in_valid & in_ready: latch a, b, op; step=0; go to EXEC.
  - Otherwise hold.
- EXEC: exactly one NAND evaluation per cycle on the single NAND cell. Its inputs are muxed by (op, step), and its output is captured at the edge.
  - NOT (1 step): s0 y=NAND(a,a).
  - AND (2 steps): s0 t=NAND(a,b); s1 y=NAND(t,t).
  - OR (3 steps): s0 t=NAND(a,a); s1 u=NAND(b,b); s2 y=NAND(t,u).
  - XOR (4 steps): s0 t=NAND(a,b); s1 u=NAND(a,t); s2 v=NAND(b,t); s3 y=NAND(u,v).
  - Each EXEC edge increments nand_count by 1.
  - At the edge of the final step: y is written, out_valid=1, go to DONE.
  - Otherwise step increments.
- Latency: out_valid rises N edges after the accept edge, where N = 1/2/3/4 for NOT/AND/OR/XOR.
- No other logic function may be used to compute y; every result bit originates from the NAND cell.
- DONE:
  - y and out_valid hold stable while out_ready=0.
  - On an edge with out_ready=1: out_valid=0, go to IDLE; y keeps its last value.
  - A new op can be accepted no earlier than the following edge; there is no same-cycle overlap.
- Input changes on a, b, op after acceptance have no effect on the operation in flight.
- in_valid asserted while busy is ignored; it is not queued. The requester holds in_valid until in_ready=1.
- out_ready asserted outside DONE has no effect.
- nand_count wraps from 2^CNT_W-1 to 0 without stalling.

Test Plan:
- Reset then idle, with WIDTH=4 → y=0, out_valid=0, busy=0, in_ready=1, nand_count=0.
- a=1100, b=1010, issue each op with out_ready=1 held:
  - NOT → y=0011, out_valid 1 edge after accept.
  - AND → y=1000, 2 edges.
  - OR → y=1110, 3 edges.
  - XOR → y=0110, 4 edges.
  - nand_count=10 after all four.
- Backpressure: XOR a=1111, b=0101 with out_ready=0 for 5 cycles → y=1010 and out_valid stay stable. in_ready=0 throughout, and a second in_valid is ignored. Raising out_ready returns the block to IDLE on the next edge.
- Input change after accept: accept AND a=1111, b=1111, then drive a=0000 next cycle → y=1111.
- Reset mid-op: assert rst_n=0 during OR step s1 → out_valid, y, nand_count go to 0 immediately (asynchronously). After release, a fresh NOT a=0110 gives y=1001 with nand_count=1.
- Wrap check, CNT_W=3: 8 NOT ops → nand_count returns to 0; the 9th NOT gives nand_count=1.

Source files
------------

// File: rtl/nand_op_sequencer.sv
// nand_op_sequencer
//   Computes NOT/AND/OR/XOR of two WIDTH-bit operands using a single shared
//   WIDTH-bit NAND cell, one NAND evaluation per clock in EXEC.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   operation handshake (a, b, op sampled on accept)
//   a, b                operands (b unused for NOT)
//   op                  00 NOT a, 01 AND, 10 OR, 11 XOR
//   out_valid/out_ready result handshake
//   y                   registered result
//   busy                high while an operation is in flight or unconsumed
//   nand_count          NAND evaluations since reset, wraps modulo 2^CNT_W
module nand_op_sequencer #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             busy,
  output logic [CNT_W-1:0] nand_count
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t           state, state_nx;
  logic [1:0]       step;
  logic [1:0]       op_r;
  logic [WIDTH-1:0] a_r, b_r, t_r, u_r, v_r;
  logic [WIDTH-1:0] nand_x, nand_y, nand_o;
  logic             accept;
  logic             last_step;

  assign in_ready  = (state == IDLE) && rst_n;
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  // The op encoding equals the index of its final step (NOT 0 .. XOR 3).
  assign last_step = (step == op_r);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept)    state_nx = EXEC;
      EXEC:    if (last_step) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default:                state_nx = IDLE;
    endcase
  end

  // Operand mux for the shared NAND cell, selected by (op, step)
  always_comb begin
    nand_x = a_r;
    nand_y = a_r;
    case ({op_r, step})
      4'b00_00: begin nand_x = a_r; nand_y = a_r; end
      4'b01_00: begin nand_x = a_r; nand_y = b_r; end
      4'b01_01: begin nand_x = t_r; nand_y = t_r; end
      4'b10_00: begin nand_x = a_r; nand_y = a_r; end
      4'b10_01: begin nand_x = b_r; nand_y = b_r; end
      4'b10_10: begin nand_x = t_r; nand_y = u_r; end
      4'b11_00: begin nand_x = a_r; nand_y = b_r; end
      4'b11_01: begin nand_x = a_r; nand_y = t_r; end
      4'b11_10: begin nand_x = b_r; nand_y = t_r; end
      4'b11_11: begin nand_x = u_r; nand_y = v_r; end
      default:  begin nand_x = a_r; nand_y = a_r; end
    endcase
  end

  assign nand_o = ~(nand_x & nand_y);

  // Datapath: operand capture, temporaries, result and evaluation counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step       <= '0;
      op_r       <= '0;
      a_r        <= '0;
      b_r        <= '0;
      t_r        <= '0;
      u_r        <= '0;
      v_r        <= '0;
      y          <= '0;
      nand_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_r  <= a;
            b_r  <= b;
            op_r <= op;
            step <= '0;
          end
        end
        EXEC: begin
          nand_count <= nand_count + CNT_W'(1);
          if (last_step) begin
            y <= nand_o;
          end else begin
            // Intermediate results land in t/u/v by step index.
            case (step)
              2'd0:    t_r <= nand_o;
              2'd1:    u_r <= nand_o;
              default: v_r <= nand_o;
            endcase
            step <= step + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nand_op_sequencer.sv
module tb_nand_op_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, out_ready;
  logic [3:0]  a, b;
  logic [1:0]  op;
  logic        in_ready, out_valid, busy;
  logic [3:0]  y;
  logic [15:0] nand_count;

  logic        in_valid2, out_ready2;
  logic [3:0]  a2, b2;
  logic [1:0]  op2;
  logic        in_ready2, out_valid2, busy2;
  logic [3:0]  y2;
  logic [2:0]  nand_count2;

  int passes = 0;
  int total  = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  nand_op_sequencer #(.WIDTH(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .busy(busy), .nand_count(nand_count)
  );

  nand_op_sequencer #(.WIDTH(4), .CNT_W(3)) dut_w (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .a(a2), .b(b2), .op(op2), .out_valid(out_valid2), .out_ready(out_ready2),
    .y(y2), .busy(busy2), .nand_count(nand_count2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one op on the main DUT and wait (bounded) for out_valid.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [3:0] av,
                        input logic [3:0] bv, input logic [3:0] exp_y, input int exp_lat);
    int lat;
    check({tag, "_in_ready"}, in_ready, 1);
    in_valid = 1'b1; op = o; a = av; b = bv;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 10) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_y"}, y, exp_y);
  endtask

  initial begin
    int lat;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; op = '0;
    in_valid2 = 1'b0; out_ready2 = 1'b1; a2 = 4'b0110; b2 = '0; op2 = 2'b00;

    // Reset state, observed before any clock edge
    #2;
    check("rst_y", y, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_nand_count", nand_count, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("idle_in_ready", in_ready, 1);
    check("idle_busy", busy, 0);

    // Basic ops with out_ready held high
    run_op("not", 2'b00, 4'b1100, 4'b1010, 4'b0011, 1);
    tick(); check("not_release", out_valid, 0);
    run_op("and", 2'b01, 4'b1100, 4'b1010, 4'b1000, 2);
    tick(); check("and_release", out_valid, 0);
    run_op("or", 2'b10, 4'b1100, 4'b1010, 4'b1110, 3);
    tick(); check("or_release", out_valid, 0);
    run_op("xor", 2'b11, 4'b1100, 4'b1010, 4'b0110, 4);
    tick(); check("xor_release", out_valid, 0);
    check("count_after_four", nand_count, 10);

    // Backpressure: result holds, second request ignored
    out_ready = 1'b0;
    run_op("bp", 2'b11, 4'b1111, 4'b0101, 4'b1010, 4);
    in_valid = 1'b1; op = 2'b00; a = 4'b0000; b = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold_y", y, 4'b1010);
      check("bp_hold_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp_done_valid", out_valid, 0);
    check("bp_done_busy", busy, 0);
    check("bp_done_y", y, 4'b1010);
    check("bp_count", nand_count, 14);

    // Input change after accept has no effect
    check("chg_in_ready", in_ready, 1);
    in_valid = 1'b1; op = 2'b01; a = 4'b1111; b = 4'b1111;
    tick();
    in_valid = 1'b0; a = 4'b0000; b = 4'b0000; op = 2'b00;
    lat = 0;
    while (!out_valid && lat < 10) begin
      tick();
      lat++;
    end
    check("chg_latency", lat, 2);
    check("chg_y", y, 4'b1111);
    tick();

    // Reset during OR step 1
    in_valid = 1'b1; op = 2'b10; a = 4'b0011; b = 4'b0101;
    tick();
    in_valid = 1'b0;
    tick();
    check("mid_busy_before", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_out_valid", out_valid, 0);
    check("mid_y", y, 0);
    check("mid_count", nand_count, 0);
    check("mid_busy", busy, 0);
    check("mid_in_ready", in_ready, 0);
    #2 rst_n = 1'b1;
    tick();
    run_op("post_not", 2'b00, 4'b0110, 4'b0000, 4'b1001, 1);
    tick();
    check("post_count", nand_count, 1);

    // Counter wrap on the CNT_W=3 instance
    for (int i = 1; i <= 9; i++) begin
      in_valid2 = 1'b1;
      tick();
      in_valid2 = 1'b0;
      tick();
      check("wrap_valid", out_valid2, 1);
      check("wrap_y", y2, 4'b1001);
      tick();
      if (i == 7) check("wrap_count7", nand_count2, 7);
      if (i == 8) check("wrap_count8", nand_count2, 0);
      if (i == 9) check("wrap_count9", nand_count2, 1);
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
